key_event: RTL
==============

Name: key_event

Overview:
- Consumes the debounced key level produced by the key debouncer. Decodes it into single-cycle event pulses: press, release, short press, long press and optional auto-repeat.
- Sits between the key debouncers and the vending-controller FSM, which acts only on these pulses.
- One instance per key. Key is active-low: 1 = released, 0 = pressed.

Parameters:
- LONG_TIME, 50_000_000, hold cycles before a press counts as long (1 s at 50 MHz); must be >= 2.
- REPEAT_TIME, 10_000_000, auto-repeat period in cycles (200 ms); used only with KEY_EVENT_REPEAT_EN; must be >= 2.
- CNT_W, 32, hold-counter width; must hold max(LONG_TIME, REPEAT_TIME).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- key_level  input  1  debounced key level, already synchronous to clk; 0 = pressed.
- pressed  output  1  registered level, 1 while the FSM is not in IDLE.
- press_pulse  output  1  one-cycle pulse on each press.
- release_pulse  output  1  one-cycle pulse on each release.
- short_pulse  output  1  one-cycle pulse on a release that happens before LONG_TIME.
- long_pulse  output  1  one-cycle pulse when the hold reaches LONG_TIME.
- repeat_pulse  output  1  one-cycle auto-repeat pulse; tied 0 without KEY_EVENT_REPEAT_EN.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, count 0.
  - Previous-level register key_d = 1 (released).
- Edge detection:
  - fall = key_d & ~key_level.
  - rise = ~key_d & key_level.
  - key_d <= key_level every cycle.
- All outputs are registered. Each pulse is high for exactly one cycle, appearing in the cycle after the clock edge that sampled the edge (latency 1).
- State IDLE:
  - On fall: press_pulse, count <= 0, go to PRESS.
  - Otherwise stay in IDLE.
- State PRESS:
  - On rise: release_pulse and short_pulse, go to IDLE.
  - Else if count == LONG_TIME-1: long_pulse, count <= 0, go to HOLD.
  - Else count <= count + 1.
- State HOLD:
  - On rise: release_pulse only (no short_pulse), go to IDLE.
  - Otherwise behaviour depends on the optional feature.
- Timing: long_pulse rises exactly LONG_TIME cycles after press_pulse.
- Simultaneous events: a rise in the same cycle that count reaches LONG_TIME-1 takes priority. The result is release_pulse + short_pulse and no long_pulse.
- At most one of short_pulse, long_pulse, repeat_pulse is high in any cycle.
- Reset while the key is held: after reset, key_d = 1 and key_level = 0 form a fall. press_pulse is generated on the first clock after reset deassertion. This is intended behaviour.
- Counter arithmetic: unsigned CNT_W bits. The counter never wraps past its terminal value and is cleared on every state change.

Optional Feature:
- Macro: KEY_EVENT_REPEAT_EN.
- Defined:
  - In HOLD with no rise, count increments.
  - When count == REPEAT_TIME-1: repeat_pulse, count <= 0.
  - The first repeat_pulse comes REPEAT_TIME cycles after long_pulse, then one every REPEAT_TIME cycles until release.
  - A rise in the terminal cycle wins: release_pulse only, no repeat_pulse.
- Undefined:
  - repeat_pulse is constant 0.
  - count stays at 0 in HOLD.
  - The REPEAT_TIME parameter is ignored.

Decomposition:
- Package key_event_pkg holds:
  - state encoding: IDLE = 2'd0, PRESS = 2'd1, HOLD = 2'd2;
  - default timing constants (LONG_TIME_DEF, REPEAT_TIME_DEF).
- One sub-module, key_edge_det:
  - holds the key_d register (reset 1);
  - outputs fall and rise;
  - reusable for the coin-sensor inputs.
- The FSM and the counter remain in key_event.

Test Plan (LONG_TIME=10, REPEAT_TIME=4):
- Reset with key_level=1, then idle 20 cycles -> all outputs 0, pressed 0.
- key_level 1→0, hold 5 cycles, then 0→1 -> press_pulse 1 cycle after the fall; short_pulse and release_pulse together, 1 cycle after the rise; no long_pulse.
- Hold key_level=0 for 30 cycles, then release -> long_pulse exactly 10 cycles after press_pulse; release_pulse only, no short_pulse. With KEY_EVENT_REPEAT_EN: repeat_pulse at +4, +8, +12, +16 cycles after long_pulse (4 pulses), none after release. Without it: repeat_pulse always 0.
- Release timed so the rise lands on the count==9 edge -> short_pulse + release_pulse, no long_pulse.
- Assert rst_n low mid-HOLD while key_level=0, then deassert -> outputs cleared; press_pulse on the first clock after deassertion; long_pulse 10 cycles later.
- Glitch-free toggling every 3 cycles for 50 cycles -> press_pulse and short_pulse counts equal the number of falls; pressed tracks the key with 1-cycle lag.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared definitions for the key event decoder.
//   key_state_e      : FSM state encoding (IDLE, PRESS, HOLD)
//   LONG_TIME_DEF    : default long-press hold time in clk cycles (1 s at 50 MHz)
//   REPEAT_TIME_DEF  : default auto-repeat period in clk cycles (200 ms at 50 MHz)
//   CNT_W_DEF        : default hold-counter width
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } key_state_e;

  localparam int unsigned LONG_TIME_DEF   = 50_000_000;
  localparam int unsigned REPEAT_TIME_DEF = 10_000_000;
  localparam int unsigned CNT_W_DEF       = 32;

endpackage

// File: rtl/key_edge_det.sv
// Edge detector for a level that is already synchronous to clk.
// Keeps the previous level (reset to 1, released / inactive) and flags edges.
// The same block serves the coin-sensor inputs.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   key_level  : current synchronous level
//   fall       : previous level 1, current level 0 (combinational)
//   rise       : previous level 0, current level 1 (combinational)
module key_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic key_level,
  output logic fall,
  output logic rise
);

  logic key_d_q;
  logic key_d_d;

  always_comb begin
    key_d_d = key_level;
  end

  // Reset to released so a key held through reset produces a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_d_q <= 1'b1;
    else        key_d_q <= key_d_d;
  end

  assign fall = key_d_q & ~key_level;
  assign rise = ~key_d_q & key_level;

endmodule

// File: rtl/key_event.sv
// Key event decoder: turns a debounced active-low key level into
// single-cycle press / release / short / long / repeat pulses for the
// vending-controller FSM. One instance per key.
// Optional feature macro: KEY_EVENT_REPEAT_EN (auto-repeat while held).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   key_level     : debounced synchronous key level, 0 = pressed
//   pressed       : registered, 1 while the FSM is not in IDLE
//   press_pulse   : one cycle per press
//   release_pulse : one cycle per release
//   short_pulse   : release before the long-press time
//   long_pulse    : hold reached LONG_TIME cycles
//   repeat_pulse  : auto-repeat, constant 0 without KEY_EVENT_REPEAT_EN
//
// state | meaning
// IDLE  | key released, waiting for a fall
// PRESS | key down, counting toward LONG_TIME
// HOLD  | long press reported, waiting for release (repeating if enabled)
module key_event
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_TIME   = LONG_TIME_DEF,
  parameter int unsigned REPEAT_TIME = REPEAT_TIME_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_level,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  if (LONG_TIME < 2) begin : g_bad_long
    $error("key_event: LONG_TIME must be >= 2");
  end
  if (REPEAT_TIME < 2) begin : g_bad_repeat
    $error("key_event: REPEAT_TIME must be >= 2");
  end
  if ($clog2(LONG_TIME) > CNT_W) begin : g_bad_width
    $error("key_event: CNT_W too narrow for LONG_TIME");
  end

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_TIME - 1);

  logic fall;
  logic rise;

  key_edge_det u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_level (key_level),
    .fall      (fall),
    .rise      (rise)
  );

  key_state_e       state_q,   state_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic             pressed_q, pressed_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;
  logic             short_q,   short_d;
  logic             long_q,    long_d;
  logic             repeat_d;

`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_TIME - 1);
  logic repeat_q;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          press_d = 1'b1;
          count_d = '0;
          state_d = PRESS;
        end
      end
      PRESS: begin
        // Release on the terminal cycle still counts as a short press.
        if (rise) begin
          release_d = 1'b1;
          short_d   = 1'b1;
          count_d   = '0;
          state_d   = IDLE;
        end else if (count_q == LONG_TC) begin
          long_d  = 1'b1;
          count_d = '0;
          state_d = HOLD;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (rise) begin
          release_d = 1'b1;
          count_d   = '0;
          state_d   = IDLE;
        end else begin
`ifdef KEY_EVENT_REPEAT_EN
          if (count_q == REPEAT_TC) begin
            repeat_d = 1'b1;
            count_d  = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
`else
          count_d = '0;
`endif
        end
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
    pressed_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      repeat_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
`ifdef KEY_EVENT_REPEAT_EN
      repeat_q  <= repeat_d;
`endif
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
`ifdef KEY_EVENT_REPEAT_EN
  assign repeat_pulse  = repeat_q;
`else
  // repeat_d is always 0 here; kept so both builds share one FSM body.
  logic unused_repeat;
  assign unused_repeat = repeat_d;
  assign repeat_pulse  = 1'b0;
`endif

endmodule
